// File: rtl/edit_controller_pkg.sv
// edit_controller_pkg: shared constants, state encoding and key priority order
package edit_controller_pkg;
  localparam logic [1:0] SCR_TIME  = 2'd0;
  localparam logic [1:0] SCR_DATE  = 2'd1;
  localparam logic [1:0] SCR_ALARM = 2'd2;
  localparam int unsigned POS_MAX = 5;
  typedef enum logic {VIEW = 1'b0, EDIT = 1'b1} state_t;
  // key index doubles as priority: lower index wins when presses coincide
  typedef enum logic [1:0] {KEY_MODE = 2'd0, KEY_SET = 2'd1, KEY_PLUS = 2'd2, KEY_MINUS = 2'd3} key_t;
endpackage

// File: rtl/edit_controller_if.sv
// edit_controller_if: key pins, 1 Hz tick and edit/display status bundle
//  slave  (controller): takes tick_1hz and raw active-low keys, drives screen,
//                       EditMode, EditPos, KeyPlusOut/KeyMinusOut strobes, blink
//  master (pins/counters side): the opposite directions
interface edit_controller_if;
  logic       tick_1hz;
  logic       KeyMode;
  logic       KeySet;
  logic       KeyPlus;
  logic       KeyMinus;
  logic [1:0] screen;
  logic       EditMode;
  logic [2:0] EditPos;
  logic       KeyPlusOut;
  logic       KeyMinusOut;
  logic       blink;
  modport slave (
    input  tick_1hz, KeyMode, KeySet, KeyPlus, KeyMinus,
    output screen, EditMode, EditPos, KeyPlusOut, KeyMinusOut, blink
  );
  modport master (
    output tick_1hz, KeyMode, KeySet, KeyPlus, KeyMinus,
    input  screen, EditMode, EditPos, KeyPlusOut, KeyMinusOut, blink
  );
endinterface

// File: rtl/edit_controller_key_debounce.sv
// key_debounce: synchronise and debounce one active-low key, pulse press on accepted 1->0
//  clk, reset (sync, active-low), raw key in; press is a one-cycle high pulse
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);
  logic s1, s2, stable, armed;
  logic [CW-1:0] cnt;
  // sync flops reset low so a key held through reset never looks released,
  // and arming needs a genuinely high synced level
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b1;
      armed  <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      armed <= armed | (stable & s2);
      press <= 1'b0;
      if (s2 == stable) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYC)) begin
        stable <= s2;
        cnt    <= '0;
        press  <= armed & ~s2;
      end else cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/edit_controller.sv
// edit_controller: screen selection and digit-edit sequencing for the clock/calendar counters
//  clk, reset (sync, active-low); bus (slave): raw keys + tick_1hz in,
//  screen/EditMode/EditPos/blink and active-low KeyPlusOut/KeyMinusOut strobes out
module edit_controller import edit_controller_pkg::*; #(
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned TIMEOUT_S    = 10,
  parameter int unsigned SCREENS      = 3,
  parameter int unsigned POS_MAX_P    = POS_MAX
) (
  input logic clk,
  input logic reset,
  edit_controller_if.slave bus
);
  localparam int unsigned IW = $clog2(TIMEOUT_S + 1);
  localparam logic [IW-1:0] TMO = IW'(TIMEOUT_S);
  localparam logic [1:0] SLAST = 2'(SCREENS - 1);
  localparam logic [2:0] PMAX = 3'(POS_MAX_P);
  logic [3:0] raw, press;
  logic mode_p, set_p, plus_p, minus_p, any_p, tick, timeout;
  state_t state, state_n;
  logic [1:0] screen_q, screen_d;
  logic [2:0] pos_q, pos_d;
  logic blink_q, blink_d, plus_q, plus_d, minus_q, minus_d;
  logic [IW-1:0] idle_q, idle_d, idle_inc;
  assign raw = {bus.KeyMinus, bus.KeyPlus, bus.KeySet, bus.KeyMode};
  genvar k;
  generate
    for (k = 0; k < 4; k++) begin : g_db
      key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
        .clk  (clk),
        .reset(reset),
        .raw  (raw[k]),
        .press(press[k])
      );
    end
  endgenerate
  assign mode_p   = press[KEY_MODE];
  assign set_p    = press[KEY_SET] & ~mode_p;
  assign plus_p   = press[KEY_PLUS] & ~press[KEY_MODE] & ~press[KEY_SET];
  assign minus_p  = press[KEY_MINUS] & ~|press[KEY_PLUS:KEY_MODE];
  assign any_p    = |press;
  assign tick     = bus.tick_1hz;
  assign idle_inc = (idle_q == TMO) ? idle_q : idle_q + 1'b1;
  // a press in the same cycle as a tick suppresses the tick entirely
  assign timeout  = tick & ~any_p & (idle_inc == TMO);
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= VIEW;
      screen_q <= SCR_TIME;
      pos_q    <= 3'd0;
      blink_q  <= 1'b1;
      plus_q   <= 1'b1;
      minus_q  <= 1'b1;
      idle_q   <= '0;
    end else begin
      state    <= state_n;
      screen_q <= screen_d;
      pos_q    <= pos_d;
      blink_q  <= blink_d;
      plus_q   <= plus_d;
      minus_q  <= minus_d;
      idle_q   <= idle_d;
    end
  end
  always_comb begin
    state_n = (state == VIEW) ? (set_p ? EDIT : VIEW)
            : (mode_p | (set_p & (pos_q == 3'd0)) | timeout) ? VIEW : EDIT;
  end
  // entering or leaving EDIT both reset the per-edit context (pos, blink, idle timer)
  always_comb begin
    screen_d = (state == VIEW && mode_p) ? ((screen_q == SLAST) ? SCR_TIME : screen_q + 2'd1) : screen_q;
    pos_d    = (state_n == VIEW) ? 3'd0 : (state == VIEW) ? PMAX : set_p ? pos_q - 3'd1 : pos_q;
    blink_d  = (state_n == VIEW || state == VIEW || plus_p || minus_p) ? 1'b1
             : (tick && !any_p) ? ~blink_q : blink_q;
    idle_d   = (state_n == VIEW || state == VIEW || any_p) ? '0 : tick ? idle_inc : idle_q;
    plus_d   = ~((state == EDIT) & plus_p);
    minus_d  = ~((state == EDIT) & minus_p);
  end
  assign bus.screen      = screen_q;
  assign bus.EditMode    = (state == EDIT);
  assign bus.EditPos     = pos_q;
  assign bus.blink       = blink_q;
  assign bus.KeyPlusOut  = plus_q;
  assign bus.KeyMinusOut = minus_q;
endmodule
